ghost_move_scheduler: RTL and testbench

- Sequences all ghosts once per game move tick.
- Owns the single shared maze-wall lookup port and serves the ghosts one at a time.
- For each ghost it fetches the open directions at the ghost's tile, broadcasts that ghost's target coordinate, and pulses that ghost's per-ghost update.
- Also owns the global scatter/chase/frightened mode timer that chooses the targets.

---
 rtl/ghost_pkg.sv | 37 +++
 rtl/ghost_mode_timer.sv | 66 ++++++
 rtl/ghost_move_scheduler.sv | 160 ++++++++++++++++
 tb/tb_ghost_move_scheduler.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost movement block: behaviour modes,
// direction encoding, the per-ghost scatter corners and the wander LFSR.
package ghost_pkg;

    typedef enum logic [1:0] {
        SCATTER    = 2'd0,
        CHASE      = 2'd1,
        FRIGHTENED = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_R = 2'd1,
        DIR_D = 2'd2,
        DIR_L = 2'd3
    } dir_t;

    // Home corner of each ghost while scattering, indexed by ghost number.
    localparam int NUM_CORNERS = 4;
    localparam int SCATTER_CORNER_X [NUM_CORNERS] = '{25, 2, 27, 0};
    localparam int SCATTER_CORNER_Y [NUM_CORNERS] = '{0, 0, 35, 35};

    // Wander generator: x^8+x^6+x^5+x^4+1, shifted towards the MSB.
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // The wall port reports open directions packed as {U,R,D,L}, so U is the MSB.
    function automatic logic dir_open(input logic [3:0] open_dirs, input dir_t d);
        logic [1:0] idx;
        idx = 2'd3 - 2'(d);
        return open_dirs[idx];
    endfunction

endpackage

// File: rtl/ghost_mode_timer.sv
// Global scatter/chase/frightened mode timer. The count advances once per
// accepted move tick; a power pellet parks the current mode and count and
// switches to frightened, which later resumes exactly where it left off.
module ghost_mode_timer
    import ghost_pkg::*;
#(
    parameter int SCATTER_TICKS = 7,
    parameter int CHASE_TICKS   = 20,
    parameter int FRIGHT_TICKS  = 6
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  tick,
    input  logic  power_pellet,
    output mode_t mode
);

    localparam int MAX_SC = (SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS;
    localparam int MAX_T  = (MAX_SC > FRIGHT_TICKS) ? MAX_SC : FRIGHT_TICKS;
    localparam int CNT_W  = $clog2(MAX_T + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] saved_cnt;
    mode_t            saved_mode;

    // Pellet has priority over the tick; the tick counts down and swaps mode on expiry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode       <= SCATTER;
            cnt        <= CNT_W'(SCATTER_TICKS);
            saved_mode <= SCATTER;
            saved_cnt  <= '0;
        end else if (power_pellet) begin
            if (mode != FRIGHTENED) begin
                saved_mode <= mode;
                saved_cnt  <= cnt;
            end
            mode <= FRIGHTENED;
            cnt  <= CNT_W'(FRIGHT_TICKS);
        end else if (tick) begin
            if (cnt <= CNT_W'(1)) begin
                case (mode)
                    SCATTER: begin
                        mode <= CHASE;
                        cnt  <= CNT_W'(CHASE_TICKS);
                    end
                    CHASE: begin
                        mode <= SCATTER;
                        cnt  <= CNT_W'(SCATTER_TICKS);
                    end
                    FRIGHTENED: begin
                        mode <= saved_mode;
                        cnt  <= saved_cnt;
                    end
                    default: begin
                        mode <= SCATTER;
                        cnt  <= CNT_W'(SCATTER_TICKS);
                    end
                endcase
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ghost_move_scheduler.sv
// Per-move-tick ghost sequencer. Walks every ghost in turn through the single
// shared wall lookup port, then issues a one-cycle update carrying the open
// directions and the mode-dependent target for that ghost.
module ghost_move_scheduler
    import ghost_pkg::*;
#(
    parameter int NUM_GHOSTS    = 4,
    parameter int COORD_W       = 6,
    parameter int SCATTER_TICKS = 7,
    parameter int CHASE_TICKS   = 20,
    parameter int FRIGHT_TICKS  = 6,
    localparam int SEL_W        = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          move_tick,
    input  logic                          power_pellet,
    input  logic [COORD_W-1:0]            pac_x,
    input  logic [COORD_W-1:0]            pac_y,
    input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_pos_x,
    input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_pos_y,
    output logic                          wall_req,
    output logic [COORD_W-1:0]            wall_x,
    output logic [COORD_W-1:0]            wall_y,
    input  logic                          wall_ack,
    input  logic [3:0]                    wall_open,
    output logic [SEL_W-1:0]              ghost_sel,
    output logic                          update,
    output logic                          can_move_u,
    output logic                          can_move_r,
    output logic                          can_move_d,
    output logic                          can_move_l,
    output logic [COORD_W-1:0]            target_x,
    output logic [COORD_W-1:0]            target_y,
    output logic [1:0]                    mode,
    output logic                          busy,
    output logic                          step_done,
    output logic                          overrun
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]       state;
    logic [SEL_W-1:0] g;
    logic [3:0]       open_q;
    logic [7:0]       lfsr;
    mode_t            cur_mode;
    logic             tick_accept;
    logic             last_ghost;
    int               corner_idx;

    assign tick_accept = move_tick && enable && (state == ST_IDLE);
    assign last_ghost  = (g == SEL_W'(NUM_GHOSTS - 1));
    assign corner_idx  = int'(g) % NUM_CORNERS;

    ghost_mode_timer #(
        .SCATTER_TICKS (SCATTER_TICKS),
        .CHASE_TICKS   (CHASE_TICKS),
        .FRIGHT_TICKS  (FRIGHT_TICKS)
    ) u_mode_timer (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick_accept),
        .power_pellet (power_pellet),
        .mode         (cur_mode)
    );

    // Sweep sequencer: lookup each ghost until acked, issue it, then signal done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            g      <= '0;
            open_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick_accept) begin
                        g     <= '0;
                        state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (wall_ack) begin
                        open_q <= wall_open;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (last_ghost) begin
                        state <= ST_DONE;
                    end else begin
                        g     <= g + SEL_W'(1);
                        state <= ST_LOOKUP;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A tick that lands while a sweep is still running is lost; remember that it happened.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (move_tick && (state != ST_IDLE)) begin
            overrun <= 1'b1;
        end
    end

    // Wander source advances once per issued ghost so each frightened ghost gets a fresh target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else if (state == ST_ISSUE) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Target for the ghost being issued, chosen by the live mode so mid-sweep changes apply at once.
    always_comb begin
        target_x = '0;
        target_y = '0;
        if (state == ST_ISSUE) begin
            case (cur_mode)
                CHASE: begin
                    target_x = pac_x;
                    target_y = pac_y;
                end
                FRIGHTENED: begin
                    target_x = COORD_W'(lfsr[7:5]);
                    target_y = COORD_W'(lfsr[2:0]);
                end
                default: begin
                    target_x = COORD_W'(SCATTER_CORNER_X[corner_idx]);
                    target_y = COORD_W'(SCATTER_CORNER_Y[corner_idx]);
                end
            endcase
        end
    end

    assign wall_req   = (state == ST_LOOKUP);
    assign wall_x     = wall_req ? ghost_pos_x[int'(g)*COORD_W +: COORD_W] : '0;
    assign wall_y     = wall_req ? ghost_pos_y[int'(g)*COORD_W +: COORD_W] : '0;
    assign update     = (state == ST_ISSUE);
    assign ghost_sel  = g;
    assign can_move_u = dir_open(open_q, DIR_U);
    assign can_move_r = dir_open(open_q, DIR_R);
    assign can_move_d = dir_open(open_q, DIR_D);
    assign can_move_l = dir_open(open_q, DIR_L);
    assign busy       = (state == ST_LOOKUP) || (state == ST_ISSUE);
    assign step_done  = (state == ST_DONE);
    assign mode       = cur_mode;

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Bench for ghost_move_scheduler: directed scenarios plus a random phase, all
// checked every cycle against a transaction-level model of the sweep and timer.
module tb_ghost_move_scheduler;

    localparam int NG = 4;
    localparam int CW = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            move_tick;
    logic            power_pellet;
    logic [CW-1:0]   pac_x, pac_y;
    logic [NG*CW-1:0] ghost_pos_x, ghost_pos_y;
    logic            wall_req;
    logic [CW-1:0]   wall_x, wall_y;
    logic            wall_ack;
    logic [3:0]      wall_open;
    logic [1:0]      ghost_sel;
    logic            update;
    logic            can_move_u, can_move_r, can_move_d, can_move_l;
    logic [CW-1:0]   target_x, target_y;
    logic [1:0]      mode;
    logic            busy, step_done, overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: sweep progress, captured walls, timer, wander register
    bit       m_in, m_ack, m_fin, m_ovr;
    int       m_g;
    logic [3:0] m_open;
    int       m_mode, m_rem, m_smode, m_srem;
    int       m_lfsr;
    int       corner_x [4] = '{25, 2, 27, 0};
    int       corner_y [4] = '{0, 0, 35, 35};

    // ack policy: 0 always, 1 random, 3 ghost1 waits 3, 4 ghost2 never acked
    int ack_mode = 0;
    int lk_cnt   = 0;
    int lk_delay = 0;

    int upd_rel [$];
    int done_rel, req_count, upd_count, first_sel, last_tick_cyc;
    int rec_tx [4];
    int rec_ty [4];

    ghost_move_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .move_tick    (move_tick),
        .power_pellet (power_pellet),
        .pac_x        (pac_x),
        .pac_y        (pac_y),
        .ghost_pos_x  (ghost_pos_x),
        .ghost_pos_y  (ghost_pos_y),
        .wall_req     (wall_req),
        .wall_x       (wall_x),
        .wall_y       (wall_y),
        .wall_ack     (wall_ack),
        .wall_open    (wall_open),
        .ghost_sel    (ghost_sel),
        .update       (update),
        .can_move_u   (can_move_u),
        .can_move_r   (can_move_r),
        .can_move_d   (can_move_d),
        .can_move_l   (can_move_l),
        .target_x     (target_x),
        .target_y     (target_y),
        .mode         (mode),
        .busy         (busy),
        .step_done    (step_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int modelTargetX();
        if (m_mode == 1) return int'(pac_x);
        if (m_mode == 2) return (m_lfsr >> 5) & 7;
        return corner_x[m_g];
    endfunction

    function automatic int modelTargetY();
        if (m_mode == 1) return int'(pac_y);
        if (m_mode == 2) return m_lfsr & 7;
        return corner_y[m_g];
    endfunction

    // model advance on each rising edge, using the inputs the bench drove
    always @(posedge clk) begin
        bit acc;
        int fb;
        cyc++;
        if (!reset) begin
            m_in = 0; m_ack = 0; m_fin = 0; m_ovr = 0; m_g = 0; m_open = '0;
            m_mode = 0; m_rem = 7; m_smode = 0; m_srem = 0; m_lfsr = 'hA5;
        end else begin
            acc = move_tick && enable && !m_in && !m_fin;
            if (move_tick && (m_in || m_fin)) m_ovr = 1;
            if (power_pellet) begin
                if (m_mode != 2) begin
                    m_smode = m_mode;
                    m_srem  = m_rem;
                end
                m_mode = 2;
                m_rem  = 6;
            end else if (acc) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    if (m_mode == 0)      begin m_mode = 1; m_rem = 20; end
                    else if (m_mode == 1) begin m_mode = 0; m_rem = 7;  end
                    else                  begin m_mode = m_smode; m_rem = m_srem; end
                end
            end
            if (m_fin) begin
                m_fin = 0;
            end else if (!m_in) begin
                if (acc) begin m_in = 1; m_g = 0; m_ack = 0; end
            end else if (!m_ack) begin
                if (wall_ack) begin m_ack = 1; m_open = wall_open; end
            end else begin
                fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
                m_lfsr = ((m_lfsr << 1) & 'hFF) | fb;
                if (m_g == NG - 1) begin m_in = 0; m_fin = 1; end
                else begin m_g = m_g + 1; m_ack = 0; end
            end
        end
    end

    // per-cycle comparison against the model, plus event recording for directed checks
    always @(negedge clk) begin
        bit exp_req, exp_upd;
        if (reset === 1'b1) begin
            exp_req = m_in && !m_ack;
            exp_upd = m_in && m_ack;
            checkOutput("wall_req", wall_req, exp_req);
            checkOutput("update", update, exp_upd);
            checkOutput("busy", busy, m_in);
            checkOutput("step_done", step_done, m_fin);
            checkOutput("mode", mode, m_mode);
            checkOutput("overrun", overrun, m_ovr);
            if (exp_req) begin
                checkOutput("wall_x", wall_x, ghost_pos_x[m_g*CW +: CW]);
                checkOutput("wall_y", wall_y, ghost_pos_y[m_g*CW +: CW]);
            end
            if (exp_upd) begin
                checkOutput("ghost_sel", ghost_sel, m_g);
                checkOutput($sformatf("target_x g%0d", m_g), target_x, modelTargetX());
                checkOutput($sformatf("target_y g%0d", m_g), target_y, modelTargetY());
                checkOutput("can_move", {can_move_u, can_move_r, can_move_d, can_move_l}, m_open);
            end
            if (wall_req) req_count++;
            if (update) begin
                upd_count++;
                upd_rel.push_back(cyc - last_tick_cyc);
                if (upd_count == 1) first_sel = int'(ghost_sel);
                rec_tx[ghost_sel] = int'(target_x);
                rec_ty[ghost_sel] = int'(target_y);
            end
            if (step_done) done_rel = cyc - last_tick_cyc;
        end
    end

    // wall port responder
    always @(negedge clk) begin
        #1;
        wall_open = 4'($urandom_range(0, 15));
        if (m_in && !m_ack) begin
            if (lk_cnt == 0) begin
                case (ack_mode)
                    1:       lk_delay = $urandom_range(0, 3);
                    3:       lk_delay = (m_g == 1) ? 3 : 0;
                    4:       lk_delay = (m_g == 2) ? 1000000 : 0;
                    default: lk_delay = 0;
                endcase
            end
            wall_ack = (lk_cnt >= lk_delay);
            lk_cnt++;
        end else begin
            lk_cnt   = 0;
            wall_ack = (ack_mode == 0) ? 1'b1 : ((ack_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit tick, input bit pellet);
        @(negedge clk);
        #1;
        move_tick     = tick;
        power_pellet  = pellet;
        last_tick_cyc = cyc;
        @(negedge clk);
        #1;
        move_tick    = 1'b0;
        power_pellet = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 400; i++) begin
            if (!m_in && !m_fin) break;
            @(negedge clk);
            #1;
        end
        checkOutput("idle_busy", busy, 0);
    endtask

    task automatic doTicks(input int n);
        repeat (n) begin
            applyStimulus(1, 0);
            waitIdle();
        end
    endtask

    task automatic clearRecs();
        upd_rel.delete();
        done_rel  = -1;
        req_count = 0;
        upd_count = 0;
        first_sel = -1;
        for (int i = 0; i < 4; i++) begin
            rec_tx[i] = -1;
            rec_ty[i] = -1;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        stepCycles(2);
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        enable       = 1'b1;
        move_tick    = 1'b0;
        power_pellet = 1'b0;
        pac_x        = 6'd10;
        pac_y        = 6'd20;
        ghost_pos_x  = {6'd31, 6'd17, 6'd9, 6'd4};
        ghost_pos_y  = {6'd12, 6'd40, 6'd22, 6'd3};
        wall_ack     = 1'b0;
        wall_open    = 4'd0;
        clearRecs();
        last_tick_cyc = 0;

        stepCycles(3);
        checkOutput("rst_wall_req", wall_req, 0);
        checkOutput("rst_update", update, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_step_done", step_done, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_mode", mode, 0);
        checkOutput("rst_ghost_sel", ghost_sel, 0);
        checkOutput("rst_target", {target_x, target_y}, 0);
        checkOutput("rst_can_move", {can_move_u, can_move_r, can_move_d, can_move_l}, 0);
        reset = 1'b1;
        stepCycles(2);

        // single sweep, zero-wait ack
        ack_mode = 0;
        clearRecs();
        applyStimulus(1, 0);
        waitIdle();
        checkOutput("upd_pulses", upd_rel.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < upd_rel.size()) checkOutput($sformatf("upd_time_%0d", i), upd_rel[i], 2 * i + 2);
        checkOutput("done_time", done_rel, 9);
        checkOutput("mode_after_1", mode, 0);
        checkOutput("scatter_g0_x", rec_tx[0], 25);

        // ghost 1 ack delayed three cycles
        ack_mode = 3;
        clearRecs();
        applyStimulus(1, 0);
        waitIdle();
        checkOutput("delay_req_cycles", req_count, 7);
        checkOutput("delay_upd_count", upd_count, 4);
        ack_mode = 0;

        // scatter -> chase -> scatter
        doTicks(4);
        checkOutput("mode_after_6", mode, 0);
        doTicks(1);
        checkOutput("mode_after_7", mode, 1);
        doTicks(19);
        checkOutput("mode_chase_19", mode, 1);
        clearRecs();
        doTicks(1);
        checkOutput("mode_back_scatter", mode, 0);
        checkOutput("scatter_g2_x", rec_tx[2], 27);
        checkOutput("scatter_g2_y", rec_ty[2], 35);

        // pellet in chase with 12 remaining
        doTicks(7);
        doTicks(8);
        checkOutput("mode_chase_12", mode, 1);
        applyStimulus(0, 1);
        checkOutput("mode_pellet", mode, 2);
        doTicks(5);
        checkOutput("mode_fright_5", mode, 2);
        doTicks(1);
        checkOutput("mode_resume_chase", mode, 1);
        doTicks(11);
        checkOutput("mode_chase_11", mode, 1);
        doTicks(1);
        checkOutput("mode_chase_expired", mode, 0);

        // second pellet restarts count without re-saving
        applyStimulus(0, 1);
        doTicks(3);
        applyStimulus(0, 1);
        doTicks(5);
        checkOutput("mode_refright_5", mode, 2);
        doTicks(1);
        checkOutput("mode_resume_scatter", mode, 0);
        doTicks(6);
        checkOutput("mode_saved_cnt_6", mode, 0);
        doTicks(1);
        checkOutput("mode_saved_cnt_7", mode, 1);

        // wander sequence from seed
        doReset();
        applyStimulus(0, 1);
        clearRecs();
        applyStimulus(1, 0);
        waitIdle();
        checkOutput("fright_g0_x", rec_tx[0], 5);
        checkOutput("fright_g0_y", rec_ty[0], 5);
        checkOutput("fright_g1_x", rec_tx[1], 2);
        checkOutput("fright_g1_y", rec_ty[1], 2);
        checkOutput("fright_g2_x", rec_tx[2], 4);
        checkOutput("fright_g2_y", rec_ty[2], 5);

        // ignored tick when disabled, then tick while busy
        enable = 1'b0;
        applyStimulus(1, 0);
        checkOutput("disabled_busy", busy, 0);
        enable = 1'b1;
        checkOutput("overrun_before", overrun, 0);
        clearRecs();
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        waitIdle();
        checkOutput("overrun_set", overrun, 1);
        checkOutput("overrun_upd_count", upd_count, 4);
        stepCycles(5);
        checkOutput("overrun_sticky", overrun, 1);

        // reset during lookup of ghost 2
        applyStimulus(0, 1);
        ack_mode = 4;
        applyStimulus(1, 0);
        for (int i = 0; i < 100; i++) begin
            if (m_in && !m_ack && m_g == 2) break;
            stepCycles(1);
        end
        stepCycles(2);
        checkOutput("hold_req_g2", wall_req, 1);
        reset = 1'b0;
        #1;
        checkOutput("abort_wall_req", wall_req, 0);
        checkOutput("abort_update", update, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_mode", mode, 0);
        checkOutput("abort_overrun", overrun, 0);
        stepCycles(2);
        reset = 1'b1;
        ack_mode = 0;
        clearRecs();
        applyStimulus(1, 0);
        waitIdle();
        checkOutput("restart_first_sel", first_sel, 0);
        checkOutput("restart_upd_count", upd_count, 4);

        // random phase
        ack_mode = 1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            move_tick    = ($urandom_range(0, 5) == 0);
            power_pellet = ($urandom_range(0, 40) == 0);
            enable       = ($urandom_range(0, 7) != 0);
            pac_x        = 6'($urandom);
            pac_y        = 6'($urandom);
            if (!m_in && !m_fin && $urandom_range(0, 3) == 0) begin
                ghost_pos_x = 24'($urandom);
                ghost_pos_y = 24'($urandom);
            end
        end
        move_tick    = 1'b0;
        power_pellet = 1'b0;
        enable       = 1'b1;
        waitIdle();
        stepCycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
